// File: rtl/log_check_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler that shares one cpu_checker between two trace-log sources.
// Each record is buffered whole, then played back-to-back so source stalls never reach the checker.
module log_check_sched #(
  parameter int         MAX_LEN = 48,
  parameter logic [7:0] FILL    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req0_char,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_char,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] chk_char,
  output logic       chk_active,
  input  logic [1:0] chk_type,
  output logic       res_valid,
  output logic       res_src,
  output logic [1:0] res_type,
  output logic       busy
);
  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]    HASH     = 8'h23;
  localparam logic [PW-1:0] LAST_IDX = PW'(MAX_LEN - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, DROP, PLAY, SETTLE, SAMPLE} state_t;

  state_t        state_reg, state_next;
  logic          grant_reg, last_grant_reg;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [7:0]    rec_buf [MAX_LEN];

  logic       pick_valid, pick_src, in_valid, taking, accept, is_hash;
  logic [7:0] in_char;

  always_comb begin
    pick_valid = req0_valid | req1_valid;
    // On a tie the source that did not win last time gets the grant.
    pick_src   = (req0_valid & req1_valid) ? ~last_grant_reg : req1_valid;
    in_valid   = grant_reg ? req1_valid : req0_valid;
    in_char    = grant_reg ? req1_char : req0_char;
    taking     = (state_reg == COLLECT) || (state_reg == DROP);
    accept     = taking & in_valid;
    is_hash    = (in_char == HASH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (pick_valid) state_next = COLLECT;
      COLLECT: if (accept) begin
                 if (is_hash)                      state_next = PLAY;
                 else if (wr_ptr_reg == LAST_IDX)  state_next = DROP;
               end
      DROP:    if (accept && is_hash) state_next = IDLE;
      PLAY:    if (rd_ptr_reg == wr_ptr_reg - PW'(1)) state_next = SETTLE;
      SETTLE:  state_next = SAMPLE;
      SAMPLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = taking & ~grant_reg;
    req1_ready = taking & grant_reg;
    busy       = (state_reg != IDLE);
  end

  // Record storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (state_reg == COLLECT && accept) rec_buf[wr_ptr_reg[AW-1:0]] <= in_char;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      chk_char       <= FILL;
      chk_active     <= 1'b0;
      res_valid      <= 1'b0;
      res_src        <= 1'b0;
      res_type       <= 2'b00;
    end else begin
      res_valid <= 1'b0;
      unique case (state_reg)
        IDLE: if (pick_valid) begin
          grant_reg      <= pick_src;
          last_grant_reg <= pick_src;
          wr_ptr_reg     <= '0;
        end
        COLLECT: if (accept) begin
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (is_hash) rd_ptr_reg <= '0;
        end
        DROP: if (accept && is_hash) begin
          res_valid <= 1'b1;
          res_type  <= 2'b11;
          res_src   <= grant_reg;
        end
        PLAY: begin
          chk_char   <= rec_buf[rd_ptr_reg[AW-1:0]];
          chk_active <= 1'b1;
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
        SETTLE: begin
          chk_char   <= FILL;
          chk_active <= 1'b0;
        end
        SAMPLE: begin
          // The checker registered '#' on the previous edge, so its verdict is stable now.
          res_type  <= chk_type;
          res_src   <= grant_reg;
          res_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/log_check_sched.md
Name: log_check_sched

Overview:
- Schedules one shared `cpu_checker` instance between two CPU trace-log character sources.
- Each source supplies one record at a time, from the first character up to and including `#`, over a valid/ready handshake.
- The scheduler picks a source round-robin and buffers the whole record. It then plays the record into the checker's `char` input on consecutive cycles, so a source stall never corrupts a record.
- It samples the checker's `format_type` and reports a per-record verdict tagged with the source index.

Parameters:
- MAX_LEN, 48, record buffer depth in characters, `#` included.
- FILL, 8'h00, character driven to the checker whenever no record is being played.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- req0_char  input  8  source 0 character.
- req0_valid  input  1  source 0 character valid.
- req0_ready  output  1  source 0 character accepted when valid&ready.
- req1_char  input  8  source 1 character.
- req1_valid  input  1  source 1 character valid.
- req1_ready  output  1  source 1 character accepted when valid&ready.
- chk_char  output  8  registered character to the checker's `char` input.
- chk_active  output  1  high while chk_char carries buffered record data.
- chk_type  input  2  checker's `format_type`.
- res_valid  output  1  one-cycle verdict pulse.
- res_src  output  1  source of the reported record.
- res_type  output  2  00 malformed, 01 register write, 10 memory write, 11 overflow.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE, last_grant=1 (source 0 wins the first tie), wr/rd pointers 0. chk_char=FILL, chk_active=0, res_valid=0, res_src=0, res_type=00, both ready=0.
- Buffer: MAX_LEN x 8 storage. Pointers are $clog2(MAX_LEN+1) bits wide and never wrap within one record.
- IDLE:
  - If exactly one source is valid, grant it.
  - If both are valid, grant the one that is not last_grant.
  - On grant, update last_grant, clear wr_ptr, go to COLLECT. No character is consumed in the grant cycle.
  - If neither is valid, stay in IDLE.
- COLLECT:
  - The granted source's ready=1; the other's ready=0.
  - On valid&ready: buf[wr_ptr]<=char, wr_ptr++.
  - If the accepted char is `#`: rd_ptr<=0, go to PLAY.
  - Else if wr_ptr+1==MAX_LEN: go to DROP (the buffer is full without `#`).
  - A source with valid=0 simply stalls COLLECT; there is no timeout.
  - `^` inside a record is stored like any other character.
- DROP:
  - The granted source's ready=1; characters are accepted and discarded until `#` is accepted.
  - Then: res_valid=1, res_type=11, res_src=grant, next IDLE. The checker never sees the record; chk_char stays FILL.
- PLAY:
  - Each cycle: chk_char<=buf[rd_ptr], chk_active<=1, rd_ptr++.
  - When rd_ptr==wr_ptr-1 (the `#` is being loaded), go to SETTLE.
  - Both ready=0.
- SETTLE: chk_char<=FILL, chk_active<=0. The checker registers `#` on this edge. Next state SAMPLE.
- SAMPLE:
  - res_type<=chk_type, res_src<=grant, res_valid<=1 for exactly one cycle, next IDLE.
  - The verdict is sampled exactly 2 edges after the edge that loaded `#` onto chk_char.
- Latency: from acceptance of `#` in COLLECT to the res_valid edge is L+2 cycles, for a record of length L.
- Minimum per-record overhead: grant cycle + L accept cycles + L play cycles + SETTLE + SAMPLE.
- A new grant cannot happen in the same cycle as res_valid; the earliest new grant is the cycle after SAMPLE.
- Reset asserted mid-operation: immediate return to reset values. The partial record is lost with no verdict. The checker sees FILL.
- chk_char and res_* are all registered; there are no combinational paths from req*_char to chk_char.
- Ready outputs are combinational from state and grant only, never from valid.

Test Plan:
- Source 0 sends "^10@00003000: $1 <= 0000000a#" (29 chars), with req0_valid dropped for 3 cycles mid-record.
  - chk_char plays all 29 chars on 29 consecutive cycles, chk_active=1 throughout.
  - res_valid pulses once with res_src=0, res_type=01, 2 cycles after `#` appears on chk_char.
- Source 1 sends "^7@00003004: *00000010 <= 0000ffff#" -> res_src=1, res_type=10; req0_ready=0 for the whole transaction.
- Both sources valid in the same cycle immediately after reset, each with 3 well-formed records.
  - Grant order is 0,1,0,1,0,1.
  - res_src alternates, starting at 0.
- Source 0 sends malformed "^10@3000: $1 <= a#" -> res_type=00, res_src=0; the next record still scores correctly.
- Source 1 sends 60 characters without `#`, then `#`.
  - All 61 characters are accepted; chk_char stays FILL and chk_active stays 0.
  - Exactly one res_valid with res_type=11.
- Reset pulled low during PLAY of a 29-char record -> next cycle chk_char=FILL, busy=0, res_valid=0, both ready=0.
  - After release, a fresh record scores 01.
